// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Used by serial_subtractor (optional error logic: SERIAL_SUBTRACTOR_ERR_EN).
package serial_subtractor_pkg;

    localparam int SERIAL_SUB_DW = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = x - a - bin, with borrow out.
module full_subtractor_bit (
    input  logic x,
    input  logic a,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ a ^ bin;
    assign bout = (~x & a) | (~x & bin) | (a & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor recovering B = X - A one bit per clock, valid/ready on both sides.
// Define SERIAL_SUBTRACTOR_ERR_EN to build the borrow/MSB error flag; otherwise err is tied to 0.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int DATA_WIDTH = SERIAL_SUB_DW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH:0]   X,
    input  logic [DATA_WIDTH-1:0] A,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] B,
    output logic                  err
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH);

    state_t                state, state_next;
    logic [DATA_WIDTH:0]   x_q, a_q;
    logic [DATA_WIDTH-1:0] res_q, b_q;
    logic [CNT_W-1:0]      cnt;
    logic                  bor_q;
    logic                  bit_d, bit_bout;
    logic                  last_bit;

    assign last_bit  = (cnt == LAST_BIT);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign B         = b_q;

    full_subtractor_bit u_bit (
        .x   (x_q[cnt]),
        .a   (a_q[cnt]),
        .bin (bor_q),
        .d   (bit_d),
        .bout(bit_bout)
    );

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every datapath register is reset so a discarded operation never leaks into B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            a_q   <= '0;
            res_q <= '0;
            b_q   <= '0;
            cnt   <= '0;
            bor_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    x_q   <= X;
                    a_q   <= {1'b0, A};
                    bor_q <= 1'b0;
                    cnt   <= '0;
                end
                SHIFT: begin
                    bor_q <= bit_bout;
                    cnt   <= cnt + 1'b1;
                    // Low bits enter at the MSB and settle into place after DATA_WIDTH shifts.
                    if (last_bit) b_q   <= res_q;
                    else          res_q <= {bit_d, res_q[DATA_WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUBTRACTOR_ERR_EN
    logic err_q;

    // Final borrow means X < A; the top difference bit means X - A overflows DATA_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        err_q <= 1'b0;
        else if (state == SHIFT && last_bit) err_q <= bit_bout | bit_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (DATA_WIDTH=4); honours SERIAL_SUBTRACTOR_ERR_EN.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W:0]   X = '0;
    logic [W-1:0] A = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] B;
    logic         err;

    int n_compared = 0;
    int n_mismatched = 0;
    time accept_time = 0;

    serial_subtractor #(.DATA_WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .X        (X),
        .A        (A),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .B        (B),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference: plain integer subtraction, flagged when the difference leaves [0, 2^W).
    function automatic logic [W-1:0] ref_b(input int x, input int a);
        int diff;
        diff = x - a;
        return diff[W-1:0];
    endfunction

    function automatic logic ref_err(input int x, input int a);
`ifdef SERIAL_SUBTRACTOR_ERR_EN
        return (x - a < 0) || (x - a >= (1 << W));
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_op(input int x, input int a, input int stall, input string tag);
        logic [W-1:0] exp_b;
        logic         exp_err;
        bit           ready_bad;
        int           k;
        exp_b   = ref_b(x, a);
        exp_err = ref_err(x, a);
        @(negedge clk);
        X         = (W+1)'(x);
        A         = W'(a);
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        k = 0;
        while (in_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, " accept_wait"}, k < 50, 1);
        @(posedge clk);
        accept_time = $time;
        #1;
        in_valid = 1'b0;
        X = (W+1)'($urandom);
        A = W'($urandom);
        ready_bad = 1'b0;
        k = 0;
        while (out_valid !== 1'b1 && k < 20) begin
            if (in_ready !== 1'b0) ready_bad = 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, " latency"}, k, W + 1);
        check({tag, " in_ready_busy"}, ready_bad, 0);
        check({tag, " B"}, B, exp_b);
        check({tag, " err"}, err, exp_err);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            check({tag, " stall out_valid"}, out_valid, 1);
            check({tag, " stall B"}, B, exp_b);
            check({tag, " stall err"}, err, exp_err);
            check({tag, " stall in_ready"}, in_ready, 0);
        end
        if (stall > 0) begin
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, " release out_valid"}, out_valid, 0);
        check({tag, " release in_ready"}, in_ready, 1);
    endtask

    initial begin
        time t0;
        int  k;

        // Reset values
        #12;
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst B", B, 0);
        check("rst err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(9, 3, 0, "nominal");
        do_op(3, 5, 0, "negative");
        do_op(31, 0, 0, "overflow_msb");
        do_op(16, 1, 0, "overflow_edge");
        do_op(20, 7, 3, "backpressure");

        // Back-to-back throughput: accepts spaced W+3 cycles apart
        do_op(0, 0, 0, "zero");
        t0 = accept_time;
        do_op(15, 15, 0, "equal");
        check("throughput spacing", (accept_time - t0) / 10, W + 3);

        // Reset mid-SHIFT at cnt=2: B still holds the previous nonzero result
        do_op(12, 1, 0, "pre_reset");
        @(negedge clk);
        X = 5'd9;
        A = 4'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", out_valid, 0);
        check("midrst B", B, 0);
        check("midrst err", err, 0);
        check("midrst in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst in_ready", in_ready, 1);
        do_op(5, 5, 0, "after_reset");

        // Randomized operations against the arithmetic reference
        for (int i = 0; i < 24; i++) begin
            do_op(int'($urandom_range(0, (1 << (W + 1)) - 1)),
                  int'($urandom_range(0, (1 << W) - 1)),
                  int'($urandom_range(0, 2)), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout compared=%0d", n_compared);
        $fatal(1, "watchdog");
    end

endmodule
